// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port, multi-cycle memory bus between the instruction
// fetch port (i_*) and the data port (d_*). Each access becomes one
// req/ack bus transaction. Read data returns on registered outputs.
// stallreq holds the pipeline until every access requested this pipeline
// cycle has completed.
//
// Optional feature:
//   MEM_ARB_RR_EN  defined   -> round-robin priority between the two ports
//                  undefined -> fixed priority, data port wins
//
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   i_en, i_addr        fetch request / address (held while stallreq=1)
//   i_rdata             fetched instruction (registered)
//   d_en, d_wen         data request / byte write enables (0 = read)
//   d_addr, d_wdata     data address / store data
//   d_rdata             load data (registered, unchanged by stores)
//   stallreq            pipeline stall request (combinational)
//   bus_req, bus_wen,   registered transaction request, byte enables,
//   bus_addr, bus_wdata address and write data, stable until bus_ack
//   bus_rdata, bus_ack  read data and one-cycle completion strobe
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_en,
    input  logic [DATA_W/8-1:0] d_wen,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                stallreq,
    output logic                bus_req,
    output logic [DATA_W/8-1:0] bus_wen,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_ACC = 2'd1,
        D_ACC = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic i_done, d_done;      // port already served in this pipeline cycle
    logic pend_i, pend_d;
    logic prefer_d;            // data port wins when both are pending
    logic start_i, start_d;    // launch a transaction at this edge
    logic ack_i, ack_d;        // owning transaction completes at this edge
    logic take_i, take_d;      // completion still wanted (port not flushed)

    // A port is pending while it requests and has not been served yet.
    // Once served, its done flag masks it until the pipeline advances, so
    // a completed access is not replayed while the other port is busy.
    assign pend_i   = i_en & ~i_done;
    assign pend_d   = d_en & ~d_done;
    assign stallreq = rst & (pend_i | pend_d);

`ifdef MEM_ARB_RR_EN
    // Winner of the last contested arbitration (1 = data). Only contested
    // grants move it; a lone request does not count as winning a round.
    logic last_grant_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_grant_d <= 1'b0;
        else if (state == IDLE && pend_i && pend_d)
            last_grant_d <= prefer_d;
    end

    assign prefer_d = ~last_grant_d;
`else
    assign prefer_d = 1'b1;
`endif

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // ---------------------------------------------------------------------
    // FSM: next state. Access states always return to IDLE on ack, so a
    // new transaction never launches on the same edge as an ack.
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pend_d && (prefer_d || !pend_i))
                    state_nxt = D_ACC;
                else if (pend_i)
                    state_nxt = I_ACC;
            end
            I_ACC, D_ACC: begin
                if (bus_ack)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs (control strobes for the datapath registers).
    // bus_ack is only decoded in the access states; elsewhere it is ignored.
    // ---------------------------------------------------------------------
    always_comb begin
        start_i = 1'b0;
        start_d = 1'b0;
        ack_i   = 1'b0;
        ack_d   = 1'b0;
        case (state)
            IDLE: begin
                start_i = (state_nxt == I_ACC);
                start_d = (state_nxt == D_ACC);
            end
            I_ACC:   ack_i = bus_ack;
            D_ACC:   ack_d = bus_ack;
            default: ;
        endcase
    end

    // A port that dropped its enable mid-transaction (flush) lets the bus
    // transaction finish but discards the result.
    assign take_i = ack_i & i_en;
    assign take_d = ack_d & d_en;

    // ---------------------------------------------------------------------
    // Bus request registers: loaded at launch, held until ack.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req   <= 1'b0;
            bus_wen   <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else if (start_d) begin
            bus_req   <= 1'b1;
            bus_wen   <= d_wen;
            bus_addr  <= d_addr;
            bus_wdata <= d_wdata;
        end else if (start_i) begin
            bus_req   <= 1'b1;
            bus_wen   <= '0;
            bus_addr  <= i_addr;
            bus_wdata <= '0;
        end else if (ack_i || ack_d) begin
            bus_req   <= 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Read data capture. bus_wen still describes the finishing transaction
    // at the ack edge, so it tells loads from stores.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            if (take_i)
                i_rdata <= bus_rdata;
            if (take_d && bus_wen == '0)
                d_rdata <= bus_rdata;
        end
    end

    // ---------------------------------------------------------------------
    // Done flags: set on a wanted completion, cleared when the pipeline
    // advances (stallreq low). A port completing always has stallreq high
    // in that cycle, so set and clear never collide for the same port.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_done <= 1'b0;
            d_done <= 1'b0;
        end else begin
            if (take_i)
                i_done <= 1'b1;
            else if (!stallreq)
                i_done <= 1'b0;

            if (take_d)
                d_done <= 1'b1;
            else if (!stallreq)
                d_done <= 1'b0;
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port, multi-cycle memory bus between the Processor's instruction port (iram_*) and data port (dram_*). Sequences each access as a req/ack transaction, returns read data on registered outputs, and raises a combined stall request that holds the whole pipeline until every pending access of the current cycle has completed. Sits between the Processor top and the external memory/bus bridge.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte enables are DATA_W/8 bits

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_en  in  1  instruction fetch request; held stable while stallreq=1
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetched instruction, registered
- d_en  in  1  data access request; held stable while stallreq=1
- d_wen  in  DATA_W/8  byte write enables; 0 means read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, registered
- stallreq  out  1  pipeline stall request
- bus_req  out  1  transaction request, registered
- bus_wen  out  DATA_W/8  byte enables of current transaction, registered
- bus_addr  out  ADDR_W  transaction address, registered
- bus_wdata  out  DATA_W  transaction write data, registered
- bus_rdata  in  DATA_W  read data, valid in the bus_ack cycle
- bus_ack  in  1  one-cycle completion strobe

## Operation
- Per-port completion flags i_done, d_done. Pending: pend_i = i_en & ~i_done; pend_d = d_en & ~d_done.
- stallreq = pend_i | pend_d (combinational); forced 0 while rst=0.
- FSM states: IDLE, I_ACC, D_ACC.
  - IDLE: if pend_d (priority winner, see Configuration) -> D_ACC; else if pend_i -> I_ACC; else stay. On the transition, latch address/wen/wdata into bus_* and set bus_req=1. I_ACC drives bus_wen=0, bus_wdata=0.
  - I_ACC/D_ACC: hold bus_* stable until bus_ack. At the ack edge: bus_req=0, go to IDLE; if the owning en is still 1, capture bus_rdata into i_rdata/d_rdata (reads only; d_rdata unchanged on writes) and set the owning done flag.
- Done flags clear at any edge where stallreq=0 (pipeline advances), so a completed access is not repeated while the other port is still pending.
- en dropped mid-transaction (flush): the bus transaction still completes; the result is discarded and done is not set.
- bus_ack outside I_ACC/D_ACC: ignored.
- No new transaction starts in the same edge as an ack; IDLE is always visited for one cycle minimum.

## Timing
- Reset (rst=0): state IDLE, bus_req=0, bus_wen=0, bus_addr=0, bus_wdata=0, i_rdata=0, d_rdata=0, done flags 0, stallreq=0.
- Single access, request in cycle 0, ack in cycle k>=1: bus_req high cycles 1..k; done set at end of cycle k; stallreq high cycles 0..k, low in cycle k+1; rdata valid from cycle k+1.
- Both ports pending in cycle 0, ack delay 1 each: winner transacts cycles 1, loser cycles 3; stallreq low in cycle 4.
- Reset asserted mid-transaction: immediate return to reset values; no response owed to the bus.

## Configuration
- MEM_ARB_RR_EN defined: round-robin priority. One-bit last_grant register (reset: instruction). When both ports are pending in IDLE, the port not granted last wins.
- MEM_ARB_RR_EN undefined: fixed priority, data port always wins over instruction port.

## Test plan
- Read fetch: i_en=1, i_addr=0xBFC00000, ack 2 cycles after bus_req with bus_rdata=0x3C080001 -> bus_addr=0xBFC00000, bus_wen=0; stallreq high 3 cycles; i_rdata=0x3C080001 in the cycle stallreq drops.
- Store: d_en=1, d_wen=4'b0011, d_addr=0x80000010, d_wdata=0xDEADBEEF -> one transaction with those values; d_rdata unchanged; stallreq low after ack+1.
- Simultaneous: i_en=d_en=1, ack delay 1 -> data transaction first, then instruction (fixed); stallreq low in cycle 4; each port transacts exactly once.
- Round-robin (MEM_ARB_RR_EN): two back-to-back cycles with both ports pending -> grant order D, I, then I, D.
- Flush: drop i_en during I_ACC -> bus_req stays high until ack; i_rdata unchanged; stallreq=0 once d_en also 0.
- Reset mid-access: rst=0 while bus_req=1 -> all outputs at reset values asynchronously; after release, a new request starts a fresh transaction.
